// File: rtl/power_pulsing_sequencer_if.sv
// Signal bundle between the acquisition controller and the power-pulsing
// sequencer. The sequencer connects through the slave modport and the
// controller/pin-stage side connects through the master modport.
interface power_pulsing_sequencer_if;
  logic       PowerPulsingEnable;
  logic       AcqRequest;
  logic       ReadoutDone;
  logic       PowerOnDigital;
  logic       PowerOnAnalog;
  logic       PowerOnDac;
  logic       PowerOnAdc;
  logic       PowerReady;
  logic       ReadoutTimeout;
  logic [2:0] SeqState;

  modport master (
    output PowerPulsingEnable, AcqRequest, ReadoutDone,
    input  PowerOnDigital, PowerOnAnalog, PowerOnDac, PowerOnAdc,
           PowerReady, ReadoutTimeout, SeqState
  );

  modport slave (
    input  PowerPulsingEnable, AcqRequest, ReadoutDone,
    output PowerOnDigital, PowerOnAnalog, PowerOnDac, PowerOnAdc,
           PowerReady, ReadoutTimeout, SeqState
  );
endinterface

// File: rtl/power_pulsing_sequencer.sv
// Power-pulsing sequencer: ramps the front-end supplies in order
// (digital, analog, DAC/ADC) with settle delays, holds digital on through
// readout, and drops everything when pulsing is disabled.
// Optional macro PP_READOUT_TIMEOUT_EN adds a READOUT watchdog that returns
// to IDLE and pulses ReadoutTimeout if ReadoutDone never arrives.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | supplies off (PowerReady tracks !PowerPulsingEnable)
// DIG_UP  | digital on, waiting DIG_SETTLE before analog
// ANA_UP  | digital+analog on, waiting ANA_SETTLE before DAC/ADC
// DAC_UP  | all supplies on, waiting DAC_SETTLE before PowerReady
// ACTIVE  | all supplies on and settled, PowerReady high
// READOUT | digital held on until ReadoutDone
module power_pulsing_sequencer #(
  parameter logic [15:0] DIG_SETTLE      = 16'd100,
  parameter logic [15:0] ANA_SETTLE      = 16'd1000,
  parameter logic [15:0] DAC_SETTLE      = 16'd200,
  parameter logic [23:0] READOUT_TIMEOUT = 24'd1000000
) (
  input  logic                        Clk,
  input  logic                        Reset,
  power_pulsing_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIG_UP  = 3'd1,
    ANA_UP  = 3'd2,
    DAC_UP  = 3'd3,
    ACTIVE  = 3'd4,
    READOUT = 3'd5
  } state_e;

  // Reload values are settle-1 so a stage lasts exactly max(settle,1) cycles.
  localparam logic [15:0] DIG_LOAD = (DIG_SETTLE == 16'd0) ? 16'd0 : DIG_SETTLE - 16'd1;
  localparam logic [15:0] ANA_LOAD = (ANA_SETTLE == 16'd0) ? 16'd0 : ANA_SETTLE - 16'd1;
  localparam logic [15:0] DAC_LOAD = (DAC_SETTLE == 16'd0) ? 16'd0 : DAC_SETTLE - 16'd1;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        dig_q, dig_d;
  logic        ana_q, ana_d;
  logic        dac_q, dac_d;
  logic        ready_q, ready_d;

`ifdef PP_READOUT_TIMEOUT_EN
  localparam logic [23:0] RTO_LOAD = (READOUT_TIMEOUT == 24'd0) ? 24'd0
                                                                : READOUT_TIMEOUT - 24'd1;
  logic [23:0] rto_cnt_q, rto_cnt_d;
  logic        tmo_q, tmo_d;
`endif

  // Next-state, settle timers and registered output decode of the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef PP_READOUT_TIMEOUT_EN
    rto_cnt_d = '0;
    tmo_d     = 1'b0;
`endif

    if (!bus.PowerPulsingEnable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.AcqRequest) begin
            state_d = DIG_UP;
            cnt_d   = DIG_LOAD;
          end
        end
        DIG_UP: begin
          if (!bus.AcqRequest) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = ANA_UP;
            cnt_d   = ANA_LOAD;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ANA_UP: begin
          if (!bus.AcqRequest) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = DAC_UP;
            cnt_d   = DAC_LOAD;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        DAC_UP: begin
          if (!bus.AcqRequest) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = ACTIVE;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ACTIVE: begin
          if (!bus.AcqRequest) begin
            state_d = READOUT;
`ifdef PP_READOUT_TIMEOUT_EN
            rto_cnt_d = RTO_LOAD;
`endif
          end
        end
        READOUT: begin
          if (bus.ReadoutDone) begin
            state_d = IDLE;
          end
`ifdef PP_READOUT_TIMEOUT_EN
          else if (rto_cnt_q == '0) begin
            state_d = IDLE;
            tmo_d   = 1'b1;
          end else begin
            rto_cnt_d = rto_cnt_q - 24'd1;
          end
`endif
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    dig_d   = (state_d != IDLE);
    ana_d   = (state_d == ANA_UP) || (state_d == DAC_UP) || (state_d == ACTIVE);
    dac_d   = (state_d == DAC_UP) || (state_d == ACTIVE);
    ready_d = (state_d == ACTIVE) || ((state_d == IDLE) && !bus.PowerPulsingEnable);
  end

  // State, timer and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dig_q   <= 1'b0;
      ana_q   <= 1'b0;
      dac_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      ana_q   <= ana_d;
      dac_q   <= dac_d;
      ready_q <= ready_d;
    end
  end

`ifdef PP_READOUT_TIMEOUT_EN
  // Readout watchdog counter and its one-cycle expiry pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rto_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      rto_cnt_q <= rto_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.ReadoutTimeout = tmo_q;
`else
  assign bus.ReadoutTimeout = 1'b0;
`endif

  // DAC and ADC share one request; they always switch together.
  assign bus.PowerOnDigital = dig_q;
  assign bus.PowerOnAnalog  = ana_q;
  assign bus.PowerOnDac     = dac_q;
  assign bus.PowerOnAdc     = dac_q;
  assign bus.PowerReady     = ready_q;
  assign bus.SeqState       = state_q;

endmodule
